// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - debounced button to press/release/short/long events and mode register
// A press that is already held when reset releases is ignored until the button is seen released.
module button_event_ctrl #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int NUM_MODES     = 4,
  parameter int ACTIVE_LOW    = 0,
  localparam int MODE_W       = (NUM_MODES <= 2) ? 1 : $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_in,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              short_press,
  output logic              long_press,
  output logic              held,
  output logic [MODE_W-1:0] mode
);

  // 64-bit product: ms * Hz overflows 32 bits at realistic clock rates
  localparam longint LONG_CYCLES = (longint'(LONG_PRESS_MS) * longint'(CLK_FREQ_HZ)) / 1000;
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LONG_M1  = CNT_W'(LONG_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, PRESSED, LONG_HELD} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_d;
  logic [MODE_W-1:0] mode_d;
  logic              press_d, release_d, short_d, long_d, held_d;
  logic              btn_n;
  logic              at_long;

  assign btn_n   = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;
  assign at_long = (hold_cnt == LONG_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_IDLE;
      hold_cnt      <= '0;
      mode          <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_d;
      hold_cnt      <= hold_cnt_d;
      mode          <= mode_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      short_press   <= short_d;
      long_press    <= long_d;
      held          <= held_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      WAIT_IDLE: if (!btn_n) state_d = IDLE;
      IDLE:      if (btn_n) state_d = PRESSED;
      PRESSED: begin
        if (!btn_n)       state_d = IDLE;
        else if (at_long) state_d = LONG_HELD;
      end
      LONG_HELD: if (!btn_n) state_d = IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    hold_cnt_d = hold_cnt;
    mode_d     = mode;
    case (state)
      IDLE: begin
        if (btn_n) begin
          press_d    = 1'b1;
          hold_cnt_d = CNT_W'(1);
        end
      end
      PRESSED: begin
        if (btn_n) begin
          if (at_long) begin
            long_d = 1'b1;
            mode_d = '0;
          end else begin
            hold_cnt_d = hold_cnt + CNT_W'(1);
          end
        end else begin
          release_d = 1'b1;
          short_d   = 1'b1;
          mode_d    = (mode == MODE_MAX) ? '0 : mode + MODE_W'(1);
        end
      end
      LONG_HELD: begin
        // counter stays frozen; only the release is reported
        if (!btn_n) release_d = 1'b1;
      end
      default: ;
    endcase
    held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Consumes the clean, synchronized, debounced switch level from the input debouncer and converts it into single-cycle user-interface events: press, release, short press, long press.
- Maintains a wrapping mode register that short presses advance and long presses clear.
- The DSP pipeline's control/display logic reads it to select the active processing/view mode.
- Input is already synchronous to clk; this block performs no synchronization or debouncing.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz.
- LONG_PRESS_MS, 1000, hold time in ms that classifies a press as long.
- NUM_MODES, 4, number of modes; mode counts 0..NUM_MODES-1; must be >= 2.
- ACTIVE_LOW, 0, 1 = btn_in asserted when low; 0 = asserted when high.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  debounced switch level, synchronous to clk.
- press_pulse  output  1  one-cycle pulse on accepted press.
- release_pulse  output  1  one-cycle pulse on release of an accepted press.
- short_press  output  1  one-cycle pulse on release before the long threshold.
- long_press  output  1  one-cycle pulse when the hold reaches the long threshold.
- held  output  1  high while an accepted press is in progress.
- mode  output  MODE_W  current mode; MODE_W = max(1, $clog2(NUM_MODES)).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst); asserting rst clears state and all outputs immediately, with no clock edge required.
- Derived constants:
  - btn_n = btn_in XOR ACTIVE_LOW (combinational normalization).
  - LONG_CYCLES = (LONG_PRESS_MS*CLK_FREQ_HZ)/1000; must be >= 2.
  - hold_cnt width = $clog2(LONG_CYCLES+1).
- Outputs: all registered. Reset values: press_pulse, release_pulse, short_press, long_press, held = 0; mode = 0; hold_cnt = 0; state = WAIT_IDLE.
- FSM states: WAIT_IDLE, IDLE, PRESSED, LONG_HELD. Pulse outputs default to 0 every cycle unless set below.
- WAIT_IDLE:
  - btn_n=0 -> IDLE; no outputs.
  - btn_n=1 -> stay.
  - Purpose: a button held through reset release never generates events.
- IDLE:
  - btn_n=1 at edge k -> PRESSED.
  - press_pulse=1 and held=1 are visible after edge k.
  - hold_cnt<=1.
- PRESSED, btn_n=1:
  - If hold_cnt == LONG_CYCLES-1 -> LONG_HELD, long_press=1, mode<=0. Long therefore fires at edge k+LONG_CYCLES-1, i.e. after LONG_CYCLES consecutive asserted samples.
  - Otherwise hold_cnt++.
- PRESSED, btn_n=0:
  - -> IDLE.
  - release_pulse=1 and short_press=1 in the same cycle; held=0.
  - mode <= (mode==NUM_MODES-1) ? 0 : mode+1.
- LONG_HELD:
  - btn_n=1 -> stay; hold_cnt frozen, no further pulses, no repeat.
  - btn_n=0 -> IDLE, release_pulse=1, held=0; no short_press and no mode change.
- Latency:
  - Every event is visible on the cycle after the sampling edge at which the input condition was seen.
  - The shortest press (1 asserted sample) gives press_pulse then, on the next cycle, release_pulse+short_press. Pulses never overlap except release_pulse with short_press.
- Invariants:
  - press_pulse and long_press are mutually exclusive in any cycle (LONG_CYCLES >= 2).
  - mode is never >= NUM_MODES.
  - held == (state in {PRESSED, LONG_HELD}).
- Reset mid-operation (any state): outputs clear asynchronously; mode returns to 0; FSM re-enters WAIT_IDLE.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ_HZ=1000, LONG_PRESS_MS=8 (LONG_CYCLES=8), NUM_MODES=3, ACTIVE_LOW=0.
- Reset with btn_in=1, release rst, hold 20 cycles -> no pulses, held=0, mode=0. Then btn_in=0 for 1 cycle, then 1 -> press_pulse exactly one cycle.
- Press for 3 samples then release -> press_pulse 1 cycle, held high 3 cycles, then release_pulse and short_press together for 1 cycle; mode 0->1; long_press never asserts.
- Three short presses from mode 0 -> mode sequence 1, 2, 0 (wrap); exactly 3 short_press pulses.
- Hold exactly 7 samples -> short_press, mode advances. Hold exactly 8 samples -> long_press 1 cycle after the 8th sample, mode=0; subsequent release -> release_pulse only, no short_press.
- Hold 30 samples with mode=2 -> exactly one long_press, mode=0, held stays 1 until release; no repeats.
- Assert rst asynchronously mid-LONG_HELD (between clock edges) -> held and mode read 0 before the next edge. With ACTIVE_LOW=1 and btn_in low through reset -> no events until btn_in goes high then low.
